// File: rtl/multiplier.sv
// Sequential shift-and-add unsigned multiplier: IDLE -> CALC (W cycles) -> DONE.
// Define MULT_EARLY_TERM_EN to leave CALC as soon as the remaining multiplier bits are zero.
module multiplier #(
   parameter int unsigned DATA_WIDTH = 6
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      start,
   input  logic [DATA_WIDTH-1:0]     Operand1,
   input  logic [DATA_WIDTH-1:0]     Operand2,
   output logic [2*DATA_WIDTH-1:0]   result,
   output logic                      busy,
   output logic                      done
);

   localparam int unsigned W    = DATA_WIDTH;
   localparam int unsigned CntW = $clog2(W + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(W);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e            state_q, state_d;
   logic [2*W-1:0]    mc_q, acc_q, result_q;
   logic [W-1:0]      mp_q;
   logic [CntW-1:0]   cnt_q;

   logic [2*W-1:0]    acc_next, mc_next;
   logic [W-1:0]      mp_next;
   logic [CntW-1:0]   cnt_next;
   logic              last_step;
   logic              load;
   logic              finish;

   // Datapath next values for one CALC step
   assign acc_next = mp_q[0] ? acc_q + mc_q : acc_q;
   assign mc_next  = mc_q << 1;
   assign mp_next  = mp_q >> 1;
   assign cnt_next = cnt_q + CntW'(1);

`ifdef MULT_EARLY_TERM_EN
   assign last_step = (cnt_next == CntMax) || (mp_next == '0);
`else
   assign last_step = (cnt_next == CntMax);
`endif

   // Controller
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      finish  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               load    = 1'b1;
               state_d = StCalc;
            end
         end
         StCalc: begin
            if (last_step) begin
               finish  = 1'b1;
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         mc_q     <= '0;
         mp_q     <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         if (load) begin
            mc_q  <= {{W{1'b0}}, Operand1};
            mp_q  <= Operand2;
            acc_q <= '0;
            cnt_q <= '0;
         end else if (state_q == StCalc) begin
            mc_q  <= mc_next;
            mp_q  <= mp_next;
            acc_q <= acc_next;
            cnt_q <= cnt_next;
         end
         if (finish) begin
            result_q <= acc_next;
         end
      end
   end

   assign result = result_q;
   assign busy   = (state_q != StIdle);
   assign done   = (state_q == StDone);

endmodule

// File: tb/tb_multiplier.sv
// Directed self-checking bench for multiplier (W=6); expected latencies follow
// MULT_EARLY_TERM_EN when the bench is built with it.
module tb_multiplier;

   localparam int W = 6;

   logic           CLK;
   logic           RST;
   logic           start;
   logic [W-1:0]   Operand1;
   logic [W-1:0]   Operand2;
   logic [2*W-1:0] result;
   logic           busy;
   logic           done;

   int checks   = 0;
   int failures = 0;

   multiplier #(.DATA_WIDTH(W)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .start    (start),
      .Operand1 (Operand1),
      .Operand2 (Operand2),
      .result   (result),
      .busy     (busy),
      .done     (done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Edges from accept (inclusive) until done is visible
   function automatic int exp_edges(input logic [W-1:0] b);
`ifdef MULT_EARLY_TERM_EN
      int hi;
      hi = 0;
      for (int i = 0; i < W; i++) if (b[i]) hi = i;
      return 2 + hi;
`else
      return W + 1;
`endif
   endfunction

   // Runs one operation from an idle post-edge point; scrambles operands after accept.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int edges, output int busy_cyc,
                        output logic [2*W-1:0] res, output logic clean_end,
                        output logic res_moved);
      logic [2*W-1:0] prev;
      prev      = result;
      res_moved = 1'b0;
      Operand1  = a;
      Operand2  = b;
      start     = 1'b1;
      @(posedge CLK); #1;
      start    = 1'b0;
      Operand1 = ~a;
      Operand2 = ~b;
      edges    = 1;
      busy_cyc = busy ? 1 : 0;
      while (!done && edges < 40) begin
         if (result !== prev) res_moved = 1'b1;
         @(posedge CLK); #1;
         edges++;
         if (busy) busy_cyc++;
      end
      res = result;
      @(posedge CLK); #1;
      clean_end = !done && !busy && (result === res);
   endtask

   task automatic test_reset();
      checks++;
      if (result !== '0) begin
         failures++; $display("FAIL reset_result got=%0d exp=0", result);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++; $display("FAIL reset_flags got busy=%b done=%b exp 0 0", busy, done);
      end
   endtask

   task automatic test_basic();
      int e, bc; logic [2*W-1:0] r; logic ce, rm;
      do_op(6'd5, 6'd7, e, bc, r, ce, rm);
      checks++;
      if (r !== 12'd35) begin failures++; $display("FAIL basic_result got=%0d exp=35", r); end
      checks++;
      if (e !== exp_edges(6'd7)) begin
         failures++; $display("FAIL basic_latency got=%0d exp=%0d", e, exp_edges(6'd7));
      end
      checks++;
      if (bc !== exp_edges(6'd7)) begin
         failures++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", bc, exp_edges(6'd7));
      end
      checks++;
      if (ce !== 1'b1) begin failures++; $display("FAIL basic_done_single got=%b exp=1", ce); end
      checks++;
      if (rm !== 1'b0) begin failures++; $display("FAIL basic_result_stable got=%b exp=0", rm); end
   endtask

   task automatic test_corners();
      logic [W-1:0]   av [5] = '{6'd63, 6'd0, 6'd63, 6'd1, 6'd45};
      logic [W-1:0]   bv [5] = '{6'd63, 6'd45, 6'd0, 6'd63, 6'd1};
      logic [2*W-1:0] pv [5] = '{12'hF81, 12'd0, 12'd0, 12'd63, 12'd45};
      int e, bc; logic [2*W-1:0] r; logic ce, rm;
      for (int i = 0; i < 5; i++) begin
         do_op(av[i], bv[i], e, bc, r, ce, rm);
         checks++;
         if (r !== pv[i]) begin
            failures++;
            $display("FAIL corner_result %0dx%0d got=%0d exp=%0d", av[i], bv[i], r, pv[i]);
         end
         checks++;
         if (e !== exp_edges(bv[i])) begin
            failures++;
            $display("FAIL corner_latency %0dx%0d got=%0d exp=%0d", av[i], bv[i], e,
                     exp_edges(bv[i]));
         end
      end
   endtask

   task automatic test_early_term();
      logic [W-1:0]   bv [3] = '{6'd1, 6'd0, 6'd32};
      logic [2*W-1:0] pv [3] = '{12'd17, 12'd0, 12'd544};
      int e, bc; logic [2*W-1:0] r; logic ce, rm;
      for (int i = 0; i < 3; i++) begin
         do_op(6'd17, bv[i], e, bc, r, ce, rm);
         checks++;
         if (r !== pv[i] || e !== exp_edges(bv[i])) begin
            failures++;
            $display("FAIL early_term 17x%0d got result=%0d edges=%0d exp result=%0d edges=%0d",
                     bv[i], r, e, pv[i], exp_edges(bv[i]));
         end
      end
   endtask

   task automatic test_back_to_back();
      int e;
      logic dropped;
      Operand1 = 6'd3;
      Operand2 = 6'd4;
      start    = 1'b1;
      @(posedge CLK); #1;
      Operand1 = 6'd9;
      Operand2 = 6'd9;
      e = 1;
      dropped = 1'b0;
      while (!done && e < 40) begin
         if (!busy) dropped = 1'b1;
         @(posedge CLK); #1;
         e++;
      end
      checks++;
      if (result !== 12'd12 || e !== exp_edges(6'd4)) begin
         failures++;
         $display("FAIL b2b_first got result=%0d edges=%0d exp result=12 edges=%0d",
                  result, e, exp_edges(6'd4));
      end
      checks++;
      if (dropped !== 1'b0) begin failures++; $display("FAIL b2b_busy_gap got=1 exp=0"); end
      @(posedge CLK); #1;
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap got busy=%b exp=0", busy); end
      @(posedge CLK); #1;
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL b2b_reaccept got busy=%b exp=1", busy); end
      start = 1'b0;
      e = 1;
      while (!done && e < 40) begin
         @(posedge CLK); #1;
         e++;
      end
      checks++;
      if (result !== 12'd81 || e !== exp_edges(6'd9)) begin
         failures++;
         $display("FAIL b2b_second got result=%0d edges=%0d exp result=81 edges=%0d",
                  result, e, exp_edges(6'd9));
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_abort();
      int e, bc; logic [2*W-1:0] r; logic ce, rm;
      logic seen_done;
      Operand1 = 6'd10;
      Operand2 = 6'd10;
      start    = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      repeat (2) @(posedge CLK);
      #2 RST = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
         failures++;
         $display("FAIL abort_async got busy=%b done=%b result=%0d exp 0 0 0", busy, done, result);
      end
      @(posedge CLK); #1;
      RST = 1'b0;
      seen_done = 1'b0;
      repeat (10) begin
         @(posedge CLK); #1;
         if (done || busy) seen_done = 1'b1;
      end
      checks++;
      if (seen_done !== 1'b0) begin failures++; $display("FAIL abort_no_done got=1 exp=0"); end
      do_op(6'd2, 6'd3, e, bc, r, ce, rm);
      checks++;
      if (r !== 12'd6 || e !== exp_edges(6'd3)) begin
         failures++;
         $display("FAIL abort_recover got result=%0d edges=%0d exp result=6 edges=%0d",
                  r, e, exp_edges(6'd3));
      end
   endtask

   initial begin
      RST      = 1'b1;
      start    = 1'b0;
      Operand1 = '0;
      Operand2 = '0;
      #12;
      test_reset();
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK); #1;
      test_basic();
      test_corners();
      test_early_term();
      test_back_to_back();
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
